seg7_scan_driver: RTL and testbench



---
 rtl/seg7_pkg.sv | 39 +++
 rtl/seg7_decode.sv | 37 +++
 rtl/seg7_scan_driver.sv | 159 +++++++++++++++
 tb/tb_seg7_scan_driver.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment display blocks.
//   - Segment bit order: {a,b,c,d,e,f,g}, bit 6 = a, 1 = lit.
//   - Segment codes SEG_0..SEG_F and SEG_BLANK.
//   - Scan state encoding used by seg7_scan_driver.
package seg7_pkg;

  // Segment bit positions within a 7-bit cathode vector.
  localparam int SEG_A_BIT = 6;
  localparam int SEG_B_BIT = 5;
  localparam int SEG_C_BIT = 4;
  localparam int SEG_D_BIT = 3;
  localparam int SEG_E_BIT = 2;
  localparam int SEG_F_BIT = 1;
  localparam int SEG_G_BIT = 0;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b0011111;
  localparam logic [6:0] SEG_C     = 7'b1001110;
  localparam logic [6:0] SEG_D     = 7'b0111101;
  localparam logic [6:0] SEG_E     = 7'b1001111;
  localparam logic [6:0] SEG_F     = 7'b1000111;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DWELL = 1'b1
  } scan_state_e;

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble-to-segment decoder.
//   nibble   in  4  value to show
//   hex_en   in  1  1: A-F shown as letters, 0: A-F shown blank
//   segments out 7  {a..g}, 1 = lit
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_en,
  output logic [6:0] segments
);

  always_comb begin
    // NOTE: every path assigns segments (default first), so no latch is inferred.
    segments = SEG_BLANK;
    unique case (nibble)
      4'h0: segments = SEG_0;
      4'h1: segments = SEG_1;
      4'h2: segments = SEG_2;
      4'h3: segments = SEG_3;
      4'h4: segments = SEG_4;
      4'h5: segments = SEG_5;
      4'h6: segments = SEG_6;
      4'h7: segments = SEG_7;
      4'h8: segments = SEG_8;
      4'h9: segments = SEG_9;
      4'hA: segments = hex_en ? SEG_A : SEG_BLANK;
      4'hB: segments = hex_en ? SEG_B : SEG_BLANK;
      4'hC: segments = hex_en ? SEG_C : SEG_BLANK;
      4'hD: segments = hex_en ? SEG_D : SEG_BLANK;
      4'hE: segments = hex_en ? SEG_E : SEG_BLANK;
      4'hF: segments = hex_en ? SEG_F : SEG_BLANK;
      default: segments = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// N-digit time-multiplexed seven-segment display driver.
// Each digit is lit for REFRESH_TICKS cycles, preceded by BLANK_TICKS cycles
// with every anode off. Display inputs are snapshotted once per frame.
//   clk          in   system clock
//   rst          in   synchronous reset, active-high
//   digits       in   nibble i = digits[4i+3:4i], digit 0 rightmost
//   dp_in        in   per-digit decimal point
//   digit_en     in   per-digit enable (0 = dark)
//   lz_suppress  in   leading-zero blanking enable
//   cathodes     out  {a..g}, 1 = lit
//   dp           out  decimal point, 1 = lit
//   anodes       out  one-hot digit select, polarity from ANODE_ACTIVE_LOW
//   frame_done   out  one-cycle pulse at the end of each full scan
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS       = 4,
  parameter int REFRESH_TICKS    = 100000,
  parameter int BLANK_TICKS      = 1000,
  parameter int HEX_EN           = 0,
  parameter int ANODE_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_suppress,
  output logic [6:0]              cathodes,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   anodes,
  output logic                    frame_done
);

  localparam int MAX_TICKS = (REFRESH_TICKS > BLANK_TICKS) ? REFRESH_TICKS : BLANK_TICKS;
  localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  // Physical anode level with every digit off.
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF =
    (ANODE_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  scan_state_e             state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [IDX_W-1:0]        idx_q;

  // Per-frame snapshot of the display inputs.
  logic [4*NUM_DIGITS-1:0] digits_q;
  logic [NUM_DIGITS-1:0]   dp_q;
  logic [NUM_DIGITS-1:0]   en_q;
  logic                    lz_q;

  logic [6:0]              cathodes_q;
  logic                    dp_out_q;
  logic [NUM_DIGITS-1:0]   anodes_q;
  logic                    frame_done_q;

  logic [NUM_DIGITS-1:0]   lz_mask;
  logic                    zero_run;
  logic [6:0]              seg_raw;
  logic                    show;
  logic [6:0]              cathodes_d;
  logic                    dp_d;
  logic [NUM_DIGITS-1:0]   anodes_d;

  seg7_decode u_decode (
    .nibble   (digits_q[4*idx_q +: 4]),
    .hex_en   (HEX_EN != 0),
    .segments (seg_raw)
  );

  // Leading-zero mask: walk down from the top digit while digits stay zero.
  // Digit 0 is never part of the mask.
  always_comb begin
    lz_mask  = '0;
    // NOTE: zero_run is a combinational running flag, so it uses blocking assignments.
    zero_run = lz_q;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (zero_run && (digits_q[4*i +: 4] == 4'd0)) lz_mask[i] = 1'b1;
      else                                          zero_run   = 1'b0;
    end
  end

  // Outputs for the digit about to enter DWELL. A suppressed digit keeps
  // its anode slot but shows nothing, including its decimal point.
  always_comb begin
    show       = en_q[idx_q] && !lz_mask[idx_q];
    cathodes_d = show ? seg_raw : SEG_BLANK;
    dp_d       = show && dp_q[idx_q];
    anodes_d   = en_q[idx_q] ? (ANODE_OFF ^ (NUM_DIGITS'(1) << idx_q)) : ANODE_OFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_BLANK;
      cnt_q        <= '0;
      idx_q        <= '0;
      // NOTE: the snapshot is ordinary registers, not a RAM, so it is reset.
      // Enables reset to "all on" so the first frame shows zeros rather than nothing.
      digits_q     <= '0;
      dp_q         <= '0;
      en_q         <= '1;
      lz_q         <= 1'b0;
      cathodes_q   <= SEG_BLANK;
      dp_out_q     <= 1'b0;
      anodes_q     <= ANODE_OFF;
      frame_done_q <= 1'b0;
    end else begin
      // NOTE: all state here uses non-blocking assignments so every register
      // sees the pre-edge values.
      frame_done_q <= 1'b0;
      unique case (state_q)
        ST_BLANK: begin
          if (cnt_q == CNT_W'(BLANK_TICKS - 1)) begin
            state_q    <= ST_DWELL;
            cnt_q      <= '0;
            cathodes_q <= cathodes_d;
            dp_out_q   <= dp_d;
            anodes_q   <= anodes_d;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DWELL: begin
          if (cnt_q == CNT_W'(REFRESH_TICKS - 1)) begin
            state_q    <= ST_BLANK;
            cnt_q      <= '0;
            cathodes_q <= SEG_BLANK;
            dp_out_q   <= 1'b0;
            anodes_q   <= ANODE_OFF;
            if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
              // End of frame: pulse and take a fresh snapshot for the next frame.
              idx_q        <= '0;
              frame_done_q <= 1'b1;
              digits_q     <= digits;
              dp_q         <= dp_in;
              en_q         <= digit_en;
              lz_q         <= lz_suppress;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_BLANK;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign cathodes   = cathodes_q;
  assign dp         = dp_out_q;
  assign anodes     = anodes_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (4 digits, dwell 4, blank 2).
// Two instances share all inputs: one decodes A-F blank, one as letters.
// The reference model predicts outputs from the number of clock edges since
// reset and a model-held snapshot of the inputs taken at each frame boundary.
module tb_seg7_scan_driver;

  localparam int N     = 4;
  localparam int R     = 4;
  localparam int B     = 2;
  localparam int FRAME = N * (R + B);

  logic           clk = 1'b0;
  logic           rst;
  logic [4*N-1:0] digits;
  logic [N-1:0]   dp_in;
  logic [N-1:0]   digit_en;
  logic           lz_suppress;

  logic [6:0]     cath0, cath1;
  logic           dp0, dp1;
  logic [N-1:0]   an0, an1;
  logic           fd0, fd1;

  seg7_scan_driver #(
    .NUM_DIGITS(N), .REFRESH_TICKS(R), .BLANK_TICKS(B), .HEX_EN(0), .ANODE_ACTIVE_LOW(1)
  ) u_dut_dec (
    .clk(clk), .rst(rst), .digits(digits), .dp_in(dp_in), .digit_en(digit_en),
    .lz_suppress(lz_suppress), .cathodes(cath0), .dp(dp0), .anodes(an0), .frame_done(fd0)
  );

  seg7_scan_driver #(
    .NUM_DIGITS(N), .REFRESH_TICKS(R), .BLANK_TICKS(B), .HEX_EN(1), .ANODE_ACTIVE_LOW(1)
  ) u_dut_hex (
    .clk(clk), .rst(rst), .digits(digits), .dp_in(dp_in), .digit_en(digit_en),
    .lz_suppress(lz_suppress), .cathodes(cath1), .dp(dp1), .anodes(an1), .frame_done(fd1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state
  int             edges;
  logic [4*N-1:0] m_dig;
  logic [N-1:0]   m_dp;
  logic [N-1:0]   m_en;
  logic           m_lz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at edge %0d: observed %h expected %h", tag, edges, obs, exp);
    end
  endtask

  function automatic logic [6:0] ref_seg(input logic [3:0] v, input logic hex);
    logic [6:0] tab [16];
    tab = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
            7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
            7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
            7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
    if (!hex && v > 4'd9) return 7'b0000000;
    return tab[v];
  endfunction

  // Expected outputs after the current edge.
  task automatic compare();
    int q, d, r, hi;
    logic [N-1:0] e_an;
    logic [6:0]   e_c0, e_c1;
    logic         e_dp, e_fd, lit;
    logic [3:0]   nib;
    q    = edges % FRAME;
    e_an = '1;
    e_c0 = '0;
    e_c1 = '0;
    e_dp = 1'b0;
    e_fd = (edges > 0) && (q == 0);
    if (q >= B) begin
      d = (q - B) / (R + B);
      r = (q - B) % (R + B);
      if (r < R) begin
        // Highest non-zero digit; anything above it is a leading zero.
        hi = 0;
        for (int k = 0; k < N; k++) if (m_dig[4*k +: 4] != 4'd0) hi = k;
        nib = m_dig[4*d +: 4];
        lit = m_en[d] && !(m_lz && d > hi);
        if (m_en[d]) e_an = ~(N'(1) << d);
        if (lit) begin
          e_c0 = ref_seg(nib, 1'b0);
          e_c1 = ref_seg(nib, 1'b1);
          e_dp = m_dp[d];
        end
      end
    end
    check("anodes_dec",   32'(an0),   32'(e_an));
    check("cathodes_dec", 32'(cath0), 32'(e_c0));
    check("dp_dec",       32'(dp0),   32'(e_dp));
    check("frame_dec",    32'(fd0),   32'(e_fd));
    check("anodes_hex",   32'(an1),   32'(e_an));
    check("cathodes_hex", 32'(cath1), 32'(e_c1));
    check("dp_hex",       32'(dp1),   32'(e_dp));
    check("frame_hex",    32'(fd1),   32'(e_fd));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      edges = 0;
      m_dig = '0;
      m_dp  = '0;
      m_en  = '1;
      m_lz  = 1'b0;
    end else begin
      edges++;
      if (edges % FRAME == 0) begin
        m_dig = digits;
        m_dp  = dp_in;
        m_en  = digit_en;
        m_lz  = lz_suppress;
      end
    end
    #1;
    compare();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Advance until the frame position reaches pos; bounded to one frame.
  task automatic run_to(input int pos);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < FRAME + 1; i++) begin
      if (edges % FRAME == pos) begin
        hit = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!hit) begin
      errors++;
      $error("FAIL run_to: position %0d not reached", pos);
    end
  endtask

  initial begin
    rst         = 1'b1;
    digits      = '0;
    dp_in       = '0;
    digit_en    = '1;
    lz_suppress = 1'b0;
    edges       = 0;

    // Reset held for 3 cycles, then first frame shows the zero snapshot.
    run(3);
    rst = 1'b0;
    run(2);
    check("first_dwell_anodes",   32'(an0),   32'h0000_000E);
    check("first_dwell_cathodes", 32'(cath0), 32'h0000_007E);

    // Plain decimal scan with one decimal point.
    digits = 16'h1234;
    dp_in  = 4'b0100;
    run(3 * FRAME);

    // Leading-zero suppression.
    lz_suppress = 1'b1;
    digits      = 16'h0050;
    dp_in       = 4'b1111;
    run(2 * FRAME);
    digits = 16'h0000;
    run(2 * FRAME);
    lz_suppress = 1'b0;

    // Mid-frame change during digit 1 dwell must not affect the current frame.
    digits = 16'h1234;
    dp_in  = 4'b0000;
    run(FRAME);
    run_to(B + (R + B) + 1);
    digits = 16'h9999;
    run(2 * FRAME);

    // Hex letters versus blank decoding.
    digits = 16'hFA00;
    run(2 * FRAME);

    // Disabled digits.
    digits   = 16'h5678;
    digit_en = 4'b1010;
    run(2 * FRAME);
    digit_en = '1;

    // Randomized inputs, changed at random moments.
    for (int f = 0; f < 12; f++) begin
      digits      = 16'($urandom);
      dp_in       = 4'($urandom);
      digit_en    = 4'($urandom);
      lz_suppress = 1'($urandom);
      if ($urandom_range(0, 2) == 0) digits[15:8] = 8'h00;
      run($urandom_range(5, 40));
    end

    // Reset during digit 2 dwell restarts at digit 0 with a zero snapshot.
    digits   = 16'h8765;
    digit_en = '1;
    run(FRAME);
    run_to(B + 2 * (R + B) + 1);
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    run(2 * FRAME);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
